bresenham_stepper: RTL and testbench

Ray-cell generator sitting directly downstream of the angle-reduction stage in the Bresenham ray path. Accepts one ray per handshake: start cell, first-octant extents (dx ≥ dy ≥ 0) and the three octant flags produced by angle reduction. Emits every grid cell along the ray, one per cycle, mapped back into the original octant, on a valid/ready stream consumed by the map-update logic.

---
 rtl/bresenham_pkg.sv | 29 ++
 rtl/bresenham_unreduce.sv | 33 +++
 rtl/bresenham_stepper.sv | 162 ++++++++++++++++
 tb/tb_bresenham_stepper.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bresenham_pkg.sv
// Shared types for the Bresenham ray path: width defaults, stepper state and
// the ray / cell descriptors exchanged between stages.
package bresenham_pkg;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_LEN_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [DEF_COORD_W-1:0] x0;
        logic signed [DEF_COORD_W-1:0] y0;
        logic        [DEF_LEN_W-1:0]   dx;
        logic        [DEF_LEN_W-1:0]   dy;
        logic                          flip_x;
        logic                          flip_y;
        logic                          flip_identity;
    } ray_t;

    typedef struct packed {
        logic signed [DEF_COORD_W-1:0] x;
        logic signed [DEF_COORD_W-1:0] y;
        logic                          last;
    } cell_t;

endpackage

// File: rtl/bresenham_unreduce.sv
// Maps a first-octant step (u,v) back into the original octant as an (a,b)
// offset from the ray start. Purely combinational.
module bresenham_unreduce
    import bresenham_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic        [LEN_W-1:0]   u_i,
    input  logic        [LEN_W-1:0]   v_i,
    input  logic                      flip_x_i,
    input  logic                      flip_y_i,
    input  logic                      flip_identity_i,
    output logic signed [COORD_W-1:0] a_o,
    output logic signed [COORD_W-1:0] b_o
);

    logic [LEN_W-1:0]          sel_a;
    logic [LEN_W-1:0]          sel_b;
    logic signed [COORD_W-1:0] raw_a;
    logic signed [COORD_W-1:0] raw_b;

    // Swap is undone before the sign flips, mirroring the reduction order.
    always_comb begin
        sel_a = flip_identity_i ? v_i : u_i;
        sel_b = flip_identity_i ? u_i : v_i;
        raw_a = COORD_W'(sel_a);
        raw_b = COORD_W'(sel_b);
        a_o   = flip_x_i ? -raw_a : raw_a;
        b_o   = flip_y_i ? -raw_b : raw_b;
    end

endmodule

// File: rtl/bresenham_stepper.sv
// Walks one first-octant Bresenham ray per accepted descriptor and streams
// every cell, mapped back to the original octant, one per cycle.
module bresenham_stepper
    import bresenham_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ray_valid,
    output logic                      ray_ready,
    input  logic signed [COORD_W-1:0] x0,
    input  logic signed [COORD_W-1:0] y0,
    input  logic        [LEN_W-1:0]   dx,
    input  logic        [LEN_W-1:0]   dy,
    input  logic                      flip_x,
    input  logic                      flip_y,
    input  logic                      flip_identity,
    output logic                      cell_valid,
    input  logic                      cell_ready,
    output logic signed [COORD_W-1:0] cell_x,
    output logic signed [COORD_W-1:0] cell_y,
    output logic                      cell_last,
    output state_e                    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a raised valid stays up with stable
    // payload until its transfer completes.

    localparam int ERR_W = LEN_W + 2;

    state_e                    state_q, state_d;
    logic signed [COORD_W-1:0] x0_q, x0_d;
    logic signed [COORD_W-1:0] y0_q, y0_d;
    logic [LEN_W-1:0]          dx_q, dx_d;
    logic [LEN_W-1:0]          dy_q, dy_d;
    logic                      fx_q, fx_d;
    logic                      fy_q, fy_d;
    logic                      fi_q, fi_d;
    logic [LEN_W-1:0]          u_q, u_d;
    logic [LEN_W-1:0]          v_q, v_d;
    logic [LEN_W-1:0]          n_q, n_d;
    logic signed [ERR_W-1:0]   err_q, err_d;

    logic [LEN_W-1:0]          dy_clamped;
    logic signed [ERR_W-1:0]   err_init;
    logic signed [ERR_W-1:0]   err_diag;
    logic signed [ERR_W-1:0]   err_axis;
    logic                      err_pos;
    logic signed [COORD_W-1:0] off_a;
    logic signed [COORD_W-1:0] off_b;

    // A dy beyond dx would leave the first octant; clamp it onto the diagonal.
    assign dy_clamped = (dy > dx) ? dx : dy;
    assign err_init   = $signed({1'b0, dy_clamped, 1'b0}) - $signed({2'b00, dx});
    assign err_diag   = $signed({1'b0, dy_q, 1'b0}) - $signed({1'b0, dx_q, 1'b0});
    assign err_axis   = $signed({1'b0, dy_q, 1'b0});
    assign err_pos    = !err_q[ERR_W-1] && (err_q != '0);

    bresenham_unreduce #(
        .COORD_W(COORD_W),
        .LEN_W  (LEN_W)
    ) u_unreduce (
        .u_i            (u_q),
        .v_i            (v_q),
        .flip_x_i       (fx_q),
        .flip_y_i       (fy_q),
        .flip_identity_i(fi_q),
        .a_o            (off_a),
        .b_o            (off_b)
    );

    assign cell_x    = x0_q + off_a;
    assign cell_y    = y0_q + off_b;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        fi_d       = fi_q;
        u_d        = u_q;
        v_d        = v_q;
        n_d        = n_q;
        err_d      = err_q;
        ray_ready  = (state_q == IDLE);
        cell_valid = (state_q == RUN);
        cell_last  = (state_q == RUN) && (n_q == dx_q);
        case (state_q)
            IDLE: begin
                if (ray_valid) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    dx_d    = dx;
                    dy_d    = dy_clamped;
                    fx_d    = flip_x;
                    fy_d    = flip_y;
                    fi_d    = flip_identity;
                    u_d     = '0;
                    v_d     = '0;
                    n_d     = '0;
                    err_d   = err_init;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cell_ready) begin
                    if (cell_last) begin
                        state_d = IDLE;
                    end else begin
                        n_d = n_q + 1'b1;
                        u_d = u_q + 1'b1;
                        if (err_pos) begin
                            v_d   = v_q + 1'b1;
                            err_d = err_q + err_diag;
                        end else begin
                            err_d = err_q + err_axis;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            fx_q    <= 1'b0;
            fy_q    <= 1'b0;
            fi_q    <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
            n_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            fi_q    <= fi_d;
            u_q     <= u_d;
            v_q     <= v_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bresenham_stepper.sv
// Directed bench for bresenham_stepper: octant mapping, clamping, single-cell
// rays, back-pressure and mid-ray reset against hand-computed cell lists.
module tb_bresenham_stepper;
    import bresenham_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               ray_valid;
    logic               ray_ready;
    logic signed [15:0] x0, y0;
    logic [15:0]        dx, dy;
    logic               flip_x, flip_y, flip_identity;
    logic               cell_valid;
    logic               cell_ready;
    logic signed [15:0] cell_x, cell_y;
    logic               cell_last;
    state_e             dbg_state;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    logic signed [15:0] got_x[$];
    logic signed [15:0] got_y[$];
    logic               got_last[$];

    bresenham_stepper dut (
        .clk          (clk),
        .rst          (rst),
        .ray_valid    (ray_valid),
        .ray_ready    (ray_ready),
        .x0           (x0),
        .y0           (y0),
        .dx           (dx),
        .dy           (dy),
        .flip_x       (flip_x),
        .flip_y       (flip_y),
        .flip_identity(flip_identity),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_x       (cell_x),
        .cell_y       (cell_y),
        .cell_last    (cell_last),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_ray(input int sx, input int sy, input int sdx, input int sdy,
                            input bit sfx, input bit sfy, input bit sfi);
        @(negedge clk);
        x0            = 16'(sx);
        y0            = 16'(sy);
        dx            = 16'(sdx);
        dy            = 16'(sdy);
        flip_x        = sfx;
        flip_y        = sfy;
        flip_identity = sfi;
        ray_valid     = 1'b1;
        @(posedge clk);
        #1;
        ray_valid     = 1'b0;
    endtask

    // Records every cell seen with cell_ready held high until cell_last or budget.
    task automatic collect(input int budget, output int first_c, output bit done);
        got_x.delete();
        got_y.delete();
        got_last.delete();
        first_c    = -1;
        done       = 1'b0;
        cell_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (cell_valid) begin
                if (first_c < 0) first_c = c;
                got_x.push_back(cell_x);
                got_y.push_back(cell_y);
                got_last.push_back(cell_last);
                if (cell_last) begin
                    done = 1'b1;
                    break;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst           = 1'b1;
        ray_valid     = 1'b0;
        cell_ready    = 1'b0;
        x0            = '0;
        y0            = '0;
        dx            = '0;
        dy            = '0;
        flip_x        = 1'b0;
        flip_y        = 1'b0;
        flip_identity = 1'b0;
        repeat (3) @(negedge clk);
        compare_cnt++;
        if ({ray_ready, cell_valid, cell_last} !== 3'b100) begin
            mismatch_cnt++;
            $display("FAIL reset_flags: got ready/valid/last=%b required 100",
                     {ray_ready, cell_valid, cell_last});
        end
        compare_cnt++;
        if (cell_x !== 16'sd0 || cell_y !== 16'sd0) begin
            mismatch_cnt++;
            $display("FAIL reset_cell: got (%0d,%0d) required (0,0)", cell_x, cell_y);
        end
        compare_cnt++;
        if (dbg_state !== IDLE) begin
            mismatch_cnt++;
            $display("FAIL reset_state: got %0d required IDLE", dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_octants();
        int ex [4][5] = '{'{10, 11, 12, 13, 14}, '{10, 10, 11, 11, 12},
                          '{10,  9,  8,  7,  6}, '{10, 10,  9,  9,  8}};
        int ey [4][5] = '{'{20, 20, 21, 21, 22}, '{20, 21, 22, 23, 24},
                          '{20, 20, 19, 19, 18}, '{20, 21, 22, 23, 24}};
        bit fx [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit fy [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bit fi [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int first_c;
        bit done;
        logic signed [15:0] e;
        for (int c = 0; c < 4; c++) begin
            send_ray(10, 20, 4, 2, fx[c], fy[c], fi[c]);
            collect(40, first_c, done);
            compare_cnt++;
            if (!done || got_x.size() != 5) begin
                mismatch_cnt++;
                $display("FAIL oct%0d_count: got %0d cells (last seen=%0d) required 5 with last",
                         c, got_x.size(), done);
            end
            compare_cnt++;
            if (first_c != 0) begin
                mismatch_cnt++;
                $display("FAIL oct%0d_latency: first cell at cycle %0d required 0", c, first_c);
            end
            for (int i = 0; i < 5 && i < got_x.size(); i++) begin
                compare_cnt++;
                e = 16'(ex[c][i]);
                if (got_x[i] !== e || got_y[i] !== 16'(ey[c][i]) || got_last[i] !== (i == 4)) begin
                    mismatch_cnt++;
                    $display("FAIL oct%0d_cell%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                             c, i, got_x[i], got_y[i], got_last[i], ex[c][i], ey[c][i], (i == 4));
                end
            end
            @(negedge clk);
            compare_cnt++;
            if (ray_ready !== 1'b1 || cell_valid !== 1'b0) begin
                mismatch_cnt++;
                $display("FAIL oct%0d_after: got ready=%b valid=%b required ready=1 valid=0",
                         c, ray_ready, cell_valid);
            end
        end
    endtask

    task automatic test_single_cell();
        int first_c;
        bit done;
        send_ray(-3, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        collect(20, first_c, done);
        compare_cnt++;
        if (!done || got_x.size() != 1) begin
            mismatch_cnt++;
            $display("FAIL single_count: got %0d cells required 1", got_x.size());
        end else begin
            compare_cnt++;
            if (got_x[0] !== -16'sd3 || got_y[0] !== 16'sd5 || got_last[0] !== 1'b1) begin
                mismatch_cnt++;
                $display("FAIL single_cell: got (%0d,%0d,last=%b) required (-3,5,last=1)",
                         got_x[0], got_y[0], got_last[0]);
            end
        end
        @(negedge clk);
        compare_cnt++;
        if (cell_valid !== 1'b0 || ray_ready !== 1'b1) begin
            mismatch_cnt++;
            $display("FAIL single_after: got valid=%b ready=%b required valid=0 ready=1",
                     cell_valid, ray_ready);
        end
    endtask

    task automatic test_clamp();
        int first_c;
        bit done;
        send_ray(0, 0, 2, 7, 1'b0, 1'b0, 1'b0);
        collect(20, first_c, done);
        compare_cnt++;
        if (!done || got_x.size() != 3) begin
            mismatch_cnt++;
            $display("FAIL clamp_count: got %0d cells required 3", got_x.size());
        end
        for (int i = 0; i < 3 && i < got_x.size(); i++) begin
            compare_cnt++;
            if (got_x[i] !== 16'(i) || got_y[i] !== 16'(i) || got_last[i] !== (i == 2)) begin
                mismatch_cnt++;
                $display("FAIL clamp_cell%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                         i, got_x[i], got_y[i], got_last[i], i, i, (i == 2));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int ex [5] = '{10, 11, 12, 13, 14};
        int ey [5] = '{20, 20, 21, 21, 22};
        logic signed [15:0] sx, sy;
        logic sl;
        bit have_prev = 1'b0;
        bit done = 1'b0;
        int k = 0;
        got_x.delete();
        got_y.delete();
        got_last.delete();
        send_ray(10, 20, 4, 2, 1'b0, 1'b0, 1'b0);
        while (!done && k < 60) begin
            @(negedge clk);
            cell_ready = (k % 3 == 0);
            ray_valid  = (got_x.size() < 3);
            x0 = 16'sd999;
            y0 = -16'sd77;
            dx = 16'd9;
            if (cell_valid) begin
                if (have_prev) begin
                    compare_cnt++;
                    if (cell_x !== sx || cell_y !== sy || cell_last !== sl) begin
                        mismatch_cnt++;
                        $display("FAIL stall_hold: got (%0d,%0d,%b) required (%0d,%0d,%b)",
                                 cell_x, cell_y, cell_last, sx, sy, sl);
                    end
                end
                compare_cnt++;
                if (ray_ready !== 1'b0) begin
                    mismatch_cnt++;
                    $display("FAIL stall_ray_ready: got %b required 0 during RUN", ray_ready);
                end
                if (cell_ready) begin
                    got_x.push_back(cell_x);
                    got_y.push_back(cell_y);
                    got_last.push_back(cell_last);
                    done      = cell_last;
                    have_prev = 1'b0;
                end else begin
                    sx = cell_x;
                    sy = cell_y;
                    sl = cell_last;
                    have_prev = 1'b1;
                end
            end
            k++;
        end
        ray_valid  = 1'b0;
        cell_ready = 1'b1;
        compare_cnt++;
        if (!done || got_x.size() != 5) begin
            mismatch_cnt++;
            $display("FAIL stall_count: got %0d cells required 5", got_x.size());
        end
        for (int i = 0; i < 5 && i < got_x.size(); i++) begin
            compare_cnt++;
            if (got_x[i] !== 16'(ex[i]) || got_y[i] !== 16'(ey[i]) || got_last[i] !== (i == 4)) begin
                mismatch_cnt++;
                $display("FAIL stall_cell%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i], (i == 4));
            end
        end
        repeat (3) begin
            @(negedge clk);
            compare_cnt++;
            if (cell_valid !== 1'b0) begin
                mismatch_cnt++;
                $display("FAIL stall_no_extra_ray: got valid=%b required 0", cell_valid);
            end
        end
    endtask

    task automatic test_reset_mid_ray();
        int first_c;
        bit done;
        int seen = 0;
        send_ray(0, 0, 10, 3, 1'b0, 1'b0, 1'b0);
        cell_ready = 1'b1;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            if (cell_valid) seen++;
        end
        rst = 1'b1;
        #1;
        compare_cnt++;
        if (cell_valid !== 1'b0 || ray_ready !== 1'b1 || cell_last !== 1'b0) begin
            mismatch_cnt++;
            $display("FAIL midrst_flags: got valid=%b ready=%b last=%b required 0,1,0 (seen %0d)",
                     cell_valid, ray_ready, cell_last, seen);
        end
        compare_cnt++;
        if (cell_x !== 16'sd0 || cell_y !== 16'sd0) begin
            mismatch_cnt++;
            $display("FAIL midrst_cell: got (%0d,%0d) required (0,0)", cell_x, cell_y);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare_cnt++;
        if (cell_valid !== 1'b0 || dbg_state !== IDLE) begin
            mismatch_cnt++;
            $display("FAIL midrst_idle: got valid=%b state=%0d required 0/IDLE", cell_valid, dbg_state);
        end
        send_ray(5, 5, 1, 1, 1'b0, 1'b0, 1'b0);
        collect(20, first_c, done);
        compare_cnt++;
        if (!done || got_x.size() != 2) begin
            mismatch_cnt++;
            $display("FAIL midrst_next_count: got %0d cells required 2", got_x.size());
        end else begin
            compare_cnt++;
            if (got_x[0] !== 16'sd5 || got_y[0] !== 16'sd5 || got_last[0] !== 1'b0 ||
                got_x[1] !== 16'sd6 || got_y[1] !== 16'sd6 || got_last[1] !== 1'b1) begin
                mismatch_cnt++;
                $display("FAIL midrst_next_cells: got (%0d,%0d,%b)(%0d,%0d,%b) required (5,5,0)(6,6,1)",
                         got_x[0], got_y[0], got_last[0], got_x[1], got_y[1], got_last[1]);
            end
        end
        @(negedge clk);
        compare_cnt++;
        if (cell_valid !== 1'b0) begin
            mismatch_cnt++;
            $display("FAIL midrst_next_end: got valid=%b required 0", cell_valid);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_octants();
        test_single_cell();
        test_clamp();
        test_stall();
        test_reset_mid_ray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
